// File: rtl/disp_arbiter.sv
// disp_arbiter: round-robin share of the two-digit seven-segment display between
// three 8-bit requesters. The granted value is converted to BCD by a sequential
// double-dabble engine (8 cycles) and loaded into registered tens/ones digits.
// Values >= 100 are flagged as overflow and shown as 4'hF on both digits.
//
// Optional feature: define DISP_ARB_HOLD_EN to add a HOLD state that blocks new
// grants for HOLD_CYCLES cycles after every display update.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req[2:0]          per-requester request, held with its value until ack
//   val0/val1/val2    unsigned values from requesters 0..2
//   ack[2:0]          one-hot, one-cycle grant pulse
//   tens_o, ones_o    registered BCD digits (4'hF on overflow)
//   src_o             index of the requester currently displayed
//   ovf_o             displayed value was >= 100
//   upd_o             one-cycle pulse when the display registers change
//   busy_o            conversion (or hold) in progress
module disp_arbiter #(
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [7:0] val0,
  input  logic [7:0] val1,
  input  logic [7:0] val2,
  output logic [2:0] ack,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic [1:0] src_o,
  output logic       ovf_o,
  output logic       upd_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {StIdle, StConv, StHold} state_e;

  state_e      state_q, state_d;
  logic [1:0]  ptr_q;     // last granted index; doubles as displayed source
  logic [7:0]  shift_q;
  logic [11:0] bcd_q;
  logic [2:0]  cnt_q;
  logic [2:0]  ack_q;
  logic [3:0]  tens_q, ones_q;
  logic [1:0]  src_q;
  logic        ovf_q, upd_q;
`ifdef DISP_ARB_HOLD_EN
  localparam logic [7:0] HoldLast = 8'(HOLD_CYCLES - 1);
  logic [7:0]  hcnt_q;
`endif

  logic [1:0]  win;
  logic [7:0]  win_val;
  logic [11:0] bcd_adj;
  logic [19:0] dd_next;

  // Round-robin pick: search starts just after the last granted index.
  always_comb begin
    win = 2'd0;
    unique case (ptr_q)
      2'd0: begin
        if (req[1])      win = 2'd1;
        else if (req[2]) win = 2'd2;
        else             win = 2'd0;
      end
      2'd1: begin
        if (req[2])      win = 2'd2;
        else if (req[0]) win = 2'd0;
        else             win = 2'd1;
      end
      default: begin
        if (req[0])      win = 2'd0;
        else if (req[1]) win = 2'd1;
        else             win = 2'd2;
      end
    endcase
    unique case (win)
      2'd1:    win_val = val1;
      2'd2:    win_val = val2;
      default: win_val = val0;
    endcase
  end

  // One double-dabble step: correct nibbles >= 5, then shift {bcd, shift} left.
  always_comb begin
    bcd_adj[3:0]  = (bcd_q[3:0]  >= 4'd5) ? bcd_q[3:0]  + 4'd3 : bcd_q[3:0];
    bcd_adj[7:4]  = (bcd_q[7:4]  >= 4'd5) ? bcd_q[7:4]  + 4'd3 : bcd_q[7:4];
    bcd_adj[11:8] = (bcd_q[11:8] >= 4'd5) ? bcd_q[11:8] + 4'd3 : bcd_q[11:8];
    dd_next       = {bcd_adj[10:0], shift_q, 1'b0};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (|req) state_d = StConv;
      StConv: begin
        if (cnt_q == 3'd7) begin
`ifdef DISP_ARB_HOLD_EN
          state_d = StHold;
`else
          state_d = StIdle;
`endif
        end
      end
`ifdef DISP_ARB_HOLD_EN
      StHold: if (hcnt_q == HoldLast) state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    busy_o = (state_q != StIdle);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= 2'd2;
      shift_q <= 8'd0;
      bcd_q   <= 12'd0;
      cnt_q   <= 3'd0;
      ack_q   <= 3'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      src_q   <= 2'd0;
      ovf_q   <= 1'b0;
      upd_q   <= 1'b0;
`ifdef DISP_ARB_HOLD_EN
      hcnt_q  <= 8'd0;
`endif
    end else begin
      ack_q <= 3'd0;
      upd_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            ptr_q   <= win;
            shift_q <= win_val;
            bcd_q   <= 12'd0;
            cnt_q   <= 3'd0;
            ack_q   <= 3'b001 << win;
          end
        end
        StConv: begin
          bcd_q   <= dd_next[19:8];
          shift_q <= dd_next[7:0];
          cnt_q   <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            // Final step result goes straight to the display registers.
            if (dd_next[19:16] != 4'd0) begin
              tens_q <= 4'hF;
              ones_q <= 4'hF;
              ovf_q  <= 1'b1;
            end else begin
              tens_q <= dd_next[15:12];
              ones_q <= dd_next[11:8];
              ovf_q  <= 1'b0;
            end
            src_q <= ptr_q;
            upd_q <= 1'b1;
`ifdef DISP_ARB_HOLD_EN
            hcnt_q <= 8'd0;
`endif
          end
        end
`ifdef DISP_ARB_HOLD_EN
        StHold: hcnt_q <= hcnt_q + 8'd1;
`endif
        default: ;
      endcase
    end
  end

  assign ack    = ack_q;
  assign tens_o = tens_q;
  assign ones_o = ones_q;
  assign src_o  = src_q;
  assign ovf_o  = ovf_q;
  assign upd_o  = upd_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// Self-checking bench for disp_arbiter: directed steps plus randomized
// transactions checked against an arithmetic reference model.
module tb_disp_arbiter;

  localparam int unsigned Hold = 16;
`ifdef DISP_ARB_HOLD_EN
  localparam int Gap = 9 + Hold;
`else
  localparam int Gap = 9;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] req;
  logic [7:0] vals [3];
  logic [2:0] ack;
  logic [3:0] tens_o, ones_o;
  logic [1:0] src_o;
  logic       ovf_o, upd_o, busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_ack = 0;
  int ptr_m    = 2;

  disp_arbiter #(.HOLD_CYCLES(Hold)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .val0   (vals[0]),
    .val1   (vals[1]),
    .val2   (vals[2]),
    .ack    (ack),
    .tens_o (tens_o),
    .ones_o (ones_o),
    .src_o  (src_o),
    .ovf_o  (ovf_o),
    .upd_o  (upd_o),
    .busy_o (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin reference: first requesting index after the last grant.
  function automatic int pick(input logic [2:0] r, input int p);
    for (int k = 1; k <= 3; k++) begin
      if (r[(p + k) % 3]) return (p + k) % 3;
    end
    return -1;
  endfunction

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (ack !== 3'b000) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  // One full transaction from grant to the cycle after the update.
  task automatic txn(input bit drop_after_ack, input bit chk_gap);
    int w;
    int v;
    bit ok;
    w = pick(req, ptr_m);
    wait_ack(ok);
    check("ack_seen", 32'(ok), 32'd1);
    if (!ok) return;
    check("ack_onehot", 32'(ack), 32'(1 << w));
    if (chk_gap) check("ack_gap", 32'(cyc - last_ack), 32'(Gap));
    last_ack = cyc;
    ptr_m = w;
    v = int'(vals[w]);
    if (drop_after_ack) req = 3'b000;
    check("busy_conv", 32'(busy_o), 32'd1);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("ack_pulse", 32'(ack), 32'd0);
      check("upd_early", 32'(upd_o), 32'd0);
    end
    tick();
    check("upd_pulse", 32'(upd_o), 32'd1);
    check("src", 32'(src_o), 32'(w));
    check("ovf", 32'(ovf_o), 32'(v >= 100));
    check("tens", 32'(tens_o), (v >= 100) ? 32'hF : 32'(v / 10));
    check("ones", 32'(ones_o), (v >= 100) ? 32'hF : 32'(v % 10));
    tick();
    check("upd_one_cycle", 32'(upd_o), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},  32'(ack),    32'd0);
    check({tag, "_tens"}, 32'(tens_o), 32'd0);
    check({tag, "_ones"}, 32'(ones_o), 32'd0);
    check({tag, "_src"},  32'(src_o),  32'd0);
    check({tag, "_ovf"},  32'(ovf_o),  32'd0);
    check({tag, "_upd"},  32'(upd_o),  32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    logic [7:0] bvals [4];
    bvals[0] = 8'd99; bvals[1] = 8'd100; bvals[2] = 8'd255; bvals[3] = 8'd0;

    // Power-on reset.
    rst = 1'b1;
    req = 3'b000;
    vals[0] = 8'd0; vals[1] = 8'd0; vals[2] = 8'd0;
    tick(); tick();
    check_reset_outputs("por");
    rst = 1'b0;
    ptr_m = 2;

    // Arbitration with all requesters held: order 0,1,2,0.
    vals[0] = 8'd1; vals[1] = 8'd2; vals[2] = 8'd3;
    req = 3'b111;
    for (int k = 0; k < 4; k++) txn(k == 3, k > 0);

    // Single conversion of 57 on requester 0.
    tick();
    check("idle_busy", 32'(busy_o), 32'd0);
    vals[0] = 8'd57;
    req = 3'b001;
    txn(1'b1, 1'b0);

    // Boundaries on requester 1.
    for (int b = 0; b < 4; b++) begin
      vals[1] = bvals[b];
      req = 3'b010;
      txn(1'b1, 1'b0);
    end

    // Randomized transactions with mixed request masks.
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 3; i++) begin
        vals[i] = (n % 3 == 0) ? 8'($urandom_range(95, 105)) : 8'($urandom_range(0, 255));
      end
      req = 3'($urandom_range(1, 7));
      txn(1'b1, 1'b0);
    end

    // Reset in the middle of a conversion.
    vals[1] = 8'd42;
    req = 3'b010;
    begin
      bit ok;
      wait_ack(ok);
      check("rc_ack_seen", 32'(ok), 32'd1);
    end
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midconv");
    tick(); tick();
    check("rst_no_upd", 32'(upd_o), 32'd0);
    check("rst_no_ack", 32'(ack), 32'd0);
    rst = 1'b0;
    ptr_m = 2;
    txn(1'b1, 1'b0);

    // After reset the pointer starts at 2 again: all-request grant goes to 0.
    vals[0] = 8'd68; vals[1] = 8'd11; vals[2] = 8'd22;
    req = 3'b111;
    tick(); #2 rst = 1'b1; #1 rst = 1'b0;
    ptr_m = 2;
    txn(1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
